// File: rtl/axi4_pattern_master.sv
// AXI4 initiator: writes one INCR burst of seed+k, reads it back and counts mismatching read beats.
// One transaction outstanding at a time; every VALID/READY output is a bit of the one-hot state register.
module axi4_pattern_master #(
  parameter int                       AXI4_ADDRESS_WIDTH = 32,
  parameter int                       AXI4_DATA_WIDTH    = 32,
  parameter int                       AXI4_ID_WIDTH      = 2,
  parameter logic [AXI4_ID_WIDTH-1:0] AXI4_ID            = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] addr_i,
  input  logic [3:0]                    len_i,
  input  logic [AXI4_DATA_WIDTH-1:0]    seed_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [4:0]                    mismatch_cnt_o,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [AXI4_ADDRESS_WIDTH-1:0] m_awaddr,
  output logic [7:0]                    m_awlen,
  output logic [2:0]                    m_awsize,
  output logic [1:0]                    m_awburst,
  output logic [AXI4_ID_WIDTH-1:0]      m_awid,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  output logic [AXI4_DATA_WIDTH-1:0]    m_wdata,
  output logic [AXI4_DATA_WIDTH/8-1:0]  m_wstrb,
  output logic                          m_wlast,
  input  logic                          m_bvalid,
  output logic                          m_bready,
  input  logic [1:0]                    m_bresp,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [AXI4_ADDRESS_WIDTH-1:0] m_araddr,
  output logic [7:0]                    m_arlen,
  output logic [2:0]                    m_arsize,
  output logic [1:0]                    m_arburst,
  output logic [AXI4_ID_WIDTH-1:0]      m_arid,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  input  logic [AXI4_DATA_WIDTH-1:0]    m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rlast
);

  localparam logic [2:0] AXSIZE = 3'($clog2(AXI4_DATA_WIDTH / 8));

  localparam int S_IDLE = 0;
  localparam int S_AW   = 1;
  localparam int S_W    = 2;
  localparam int S_B    = 3;
  localparam int S_AR   = 4;
  localparam int S_R    = 5;
  localparam int S_DONE = 6;

  localparam logic [6:0] ST_IDLE = 7'b0000001;
  localparam logic [6:0] ST_AW   = 7'b0000010;
  localparam logic [6:0] ST_W    = 7'b0000100;
  localparam logic [6:0] ST_B    = 7'b0001000;
  localparam logic [6:0] ST_AR   = 7'b0010000;
  localparam logic [6:0] ST_R    = 7'b0100000;
  localparam logic [6:0] ST_DONE = 7'b1000000;

  logic [6:0]                    state_q, state_d;
  logic [AXI4_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]                    len_q, len_d;
  logic [AXI4_DATA_WIDTH-1:0]    seed_q, seed_d;
  logic [3:0]                    k_q, k_d;
  logic                          err_q, err_d;
  logic [4:0]                    mm_q, mm_d;

  logic [AXI4_DATA_WIDTH-1:0]    pattern;
  logic                          last_beat;
  logic                          w_fire, b_fire, r_fire;

  assign pattern   = seed_q + AXI4_DATA_WIDTH'(k_q);
  assign last_beat = (k_q == len_q);
  assign w_fire    = state_q[S_W] & m_wready;
  assign b_fire    = state_q[S_B] & m_bvalid;
  assign r_fire    = state_q[S_R] & m_rvalid;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      seed_q  <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
      mm_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      seed_q  <= seed_d;
      k_q     <= k_d;
      err_q   <= err_d;
      mm_q    <= mm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i)   state_d = ST_AW;
      ST_AW:   if (m_awready) state_d = ST_W;
      ST_W:    if (m_wready && last_beat) state_d = ST_B;
      ST_B:    if (m_bvalid)  state_d = ST_AR;
      ST_AR:   if (m_arready) state_d = ST_R;
      // The burst ends on whichever comes first: slave RLAST or our own beat count.
      ST_R:    if (m_rvalid && (m_rlast || last_beat)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    len_d  = len_q;
    seed_d = seed_q;
    k_d    = k_q;
    err_d  = err_q;
    mm_d   = mm_q;
    if (state_q[S_IDLE] && start_i) begin
      addr_d = addr_i;
      len_d  = len_i;
      seed_d = seed_i;
      k_d    = '0;
      err_d  = 1'b0;
      mm_d   = '0;
    end
    if (w_fire) k_d = last_beat ? 4'd0 : k_q + 4'd1;
    if (b_fire && (m_bresp != 2'b00)) err_d = 1'b1;
    if (r_fire) begin
      k_d = k_q + 4'd1;
      if (m_rdata != pattern) begin
        mm_d  = mm_q + 5'd1;
        err_d = 1'b1;
      end
      if (m_rresp != 2'b00) err_d = 1'b1;
      if (m_rlast != last_beat) err_d = 1'b1;
    end
  end

  always_comb begin
    m_awvalid      = state_q[S_AW];
    m_awaddr       = addr_q;
    m_awlen        = {4'b0000, len_q};
    m_awsize       = AXSIZE;
    m_awburst      = 2'b01;
    m_awid         = AXI4_ID;
    m_wvalid       = state_q[S_W];
    m_wdata        = pattern;
    m_wstrb        = '1;
    m_wlast        = last_beat;
    m_bready       = state_q[S_B];
    m_arvalid      = state_q[S_AR];
    m_araddr       = addr_q;
    m_arlen        = {4'b0000, len_q};
    m_arsize       = AXSIZE;
    m_arburst      = 2'b01;
    m_arid         = AXI4_ID;
    m_rready       = state_q[S_R];
    busy_o         = |state_q[S_R:S_AW];
    done_o         = state_q[S_DONE];
    err_o          = err_q;
    mismatch_cnt_o = mm_q;
  end

endmodule

// File: tb/tb_axi4_pattern_master.sv
// Bench for axi4_pattern_master: memory slave with configurable stalls and faults, plus a pattern model.
`timescale 1ns/1ps
module tb_axi4_pattern_master;

  logic        clk_i   = 1'b0;
  logic        rst_n   = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] addr_i  = '0;
  logic [3:0]  len_i   = '0;
  logic [31:0] seed_i  = '0;
  logic        busy_o, done_o, err_o;
  logic [4:0]  mismatch_cnt_o;

  logic        m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready;
  logic [31:0] m_awaddr, m_araddr, m_wdata;
  logic [7:0]  m_awlen, m_arlen;
  logic [2:0]  m_awsize, m_arsize;
  logic [1:0]  m_awburst, m_arburst, m_awid, m_arid;
  logic [3:0]  m_wstrb;
  logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0, m_arready = 1'b0;
  logic        m_rvalid = 1'b0, m_rlast = 1'b0;
  logic [1:0]  m_bresp = 2'b00, m_rresp = 2'b00;
  logic [31:0] m_rdata = '0;

  axi4_pattern_master dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
    .seed_i(seed_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .mismatch_cnt_o(mismatch_cnt_o),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awid(m_awid),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference transaction and slave fault configuration, set by the stimulus.
  logic [31:0] cur_addr, cur_seed;
  logic [3:0]  cur_len;
  int          cfg_stall = 0;
  logic [1:0]  cfg_bresp = 2'b00;
  logic [15:0] cfg_mask  = '0;
  int          cfg_early = 16;
  logic [31:0] obs_w [0:15];
  logic [31:0] mem [0:255];

  // Memory slave: decides READY/VALID at each negedge, so every transfer is known before its posedge.
  initial begin : slave
    int aw_wait, w_wait, ar_wait, w_beat, r_idx;
    logic [7:0] wbase, rbase;
    logic [3:0] rlen;
    logic b_req, b_fire, r_req, r_act, r_fire;
    aw_wait = 0; w_wait = 0; ar_wait = 0; w_beat = 0; r_idx = 0;
    wbase = '0; rbase = '0; rlen = '0;
    b_req = 0; b_fire = 0; r_req = 0; r_act = 0; r_fire = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_n) begin
        m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0; m_rlast = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; w_beat = 0; r_idx = 0;
        b_req = 0; b_fire = 0; r_req = 0; r_act = 0; r_fire = 0;
        continue;
      end
      if (b_fire) begin m_bvalid = 0; b_fire = 0; end
      if (b_req) begin m_bvalid = 1; m_bresp = cfg_bresp; b_req = 0; end
      if (m_bvalid && m_bready) b_fire = 1;

      if (r_fire) begin
        r_fire = 0;
        if (m_rlast) begin r_act = 0; m_rvalid = 0; m_rlast = 0; end
        else r_idx++;
      end
      if (r_req) begin r_act = 1; r_idx = 0; r_req = 0; end
      if (r_act) begin
        m_rvalid = 1;
        m_rdata  = mem[rbase + 8'(r_idx)] ^ (cfg_mask[r_idx] ? 32'h1 : 32'h0);
        m_rlast  = (r_idx == int'(rlen)) || (r_idx == cfg_early);
        m_rresp  = 2'b00;
      end
      if (m_rvalid && m_rready) r_fire = 1;

      m_awready = 0;
      if (m_awvalid) begin
        if (aw_wait < cfg_stall) aw_wait++;
        else begin m_awready = 1; aw_wait = 0; wbase = m_awaddr[9:2]; w_beat = 0; end
      end
      m_wready = 0;
      if (m_wvalid) begin
        if (w_wait < cfg_stall) w_wait++;
        else begin
          m_wready = 1; w_wait = 0;
          mem[wbase + 8'(w_beat)] = m_wdata;
          w_beat++;
          if (m_wlast) b_req = 1;
        end
      end
      m_arready = 0;
      if (m_arvalid) begin
        if (ar_wait < cfg_stall) ar_wait++;
        else begin
          m_arready = 1; ar_wait = 0;
          rbase = m_araddr[9:2]; rlen = m_arlen[3:0]; r_req = 1;
        end
      end
    end
  end

  // Compare process: checks every request-channel cycle against the reference transaction.
  initial begin : compare
    logic aw_hs, aw_pend, w_pend, ar_pend, done_prev;
    logic [31:0] aw_prev, w_prev, ar_prev;
    int w_idx;
    aw_hs = 0; aw_pend = 0; w_pend = 0; ar_pend = 0; done_prev = 0; w_idx = 0;
    aw_prev = '0; w_prev = '0; ar_prev = '0;
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_n) begin
        aw_hs = 0; aw_pend = 0; w_pend = 0; ar_pend = 0; done_prev = 0; w_idx = 0;
        continue;
      end
      if (aw_pend) begin
        chk("aw_valid_hold", 32'(m_awvalid), 32'd1);
        chk("aw_addr_stable", m_awaddr, aw_prev);
      end
      if (w_pend) begin
        chk("w_valid_hold", 32'(m_wvalid), 32'd1);
        chk("w_data_stable", m_wdata, w_prev);
      end
      if (ar_pend) begin
        chk("ar_valid_hold", 32'(m_arvalid), 32'd1);
        chk("ar_addr_stable", m_araddr, ar_prev);
      end
      if (m_awvalid) begin
        chk("awaddr", m_awaddr, cur_addr);
        chk("awlen", 32'(m_awlen), 32'(cur_len));
        chk("awsize", 32'(m_awsize), 32'd2);
        chk("awburst", 32'(m_awburst), 32'd1);
        chk("awid", 32'(m_awid), 32'd0);
        if (m_awready) begin aw_hs = 1; w_idx = 0; end
      end
      if (m_wvalid) begin
        chk("w_after_aw", 32'(aw_hs), 32'd1);
        if (m_wready) begin
          chk("wdata", m_wdata, cur_seed + 32'(w_idx));
          chk("wlast", 32'(m_wlast), 32'(w_idx == int'(cur_len)));
          chk("wstrb", 32'(m_wstrb), 32'hF);
          if (w_idx < 16) obs_w[w_idx] = m_wdata;
          w_idx++;
          if (m_wlast) aw_hs = 0;
        end
      end
      if (m_arvalid) begin
        chk("araddr", m_araddr, cur_addr);
        chk("arlen", 32'(m_arlen), 32'(cur_len));
        chk("arsize", 32'(m_arsize), 32'd2);
        chk("arburst", 32'(m_arburst), 32'd1);
        chk("arid", 32'(m_arid), 32'd0);
      end
      if (done_prev) chk("done_one_cycle", 32'(done_o), 32'd0);
      if (done_o) chk("busy_low_at_done", 32'(busy_o), 32'd0);
      done_prev = done_o;
      aw_pend = m_awvalid && !m_awready; aw_prev = m_awaddr;
      w_pend  = m_wvalid && !m_wready;   w_prev  = m_wdata;
      ar_pend = m_arvalid && !m_arready; ar_prev = m_araddr;
    end
  end

  task automatic start_seq(input logic [31:0] a, input logic [3:0] l, input logic [31:0] s);
    cur_addr = a; cur_len = l; cur_seed = s;
    @(negedge clk_i);
    addr_i = a; len_i = l; seed_i = s; start_i = 1;
    @(negedge clk_i);
    start_i = 0;
    // Scramble the inputs: the burst must run from the latched copies.
    addr_i = ~a; len_i = ~l; seed_i = ~s;
  endtask

  task automatic run_seq(input logic [31:0] a, input logic [3:0] l, input logic [31:0] s,
                         input int stall, input logic [1:0] br, input logic [15:0] mask,
                         input int early, input bit poke);
    int exp_mm, last, n;
    bit exp_err;
    cfg_stall = stall; cfg_bresp = br; cfg_mask = mask; cfg_early = early;
    last   = (early < int'(l)) ? early : int'(l);
    exp_mm = 0;
    for (int i = 0; i <= last; i++) if (mask[i]) exp_mm++;
    exp_err = (br != 2'b00) || (exp_mm != 0) || (early < int'(l));
    start_seq(a, l, s);
    chk("busy_after_start", 32'(busy_o), 32'd1);
    if (poke) begin
      repeat (2) @(negedge clk_i);
      addr_i = 32'h0000_0040; start_i = 1;
      @(negedge clk_i);
      start_i = 0;
    end
    n = 0;
    while (!done_o && n < 2000) begin @(negedge clk_i); n++; end
    chk("done_seen", 32'(done_o), 32'd1);
    if (done_o) begin
      chk("err_o", 32'(err_o), 32'(exp_err));
      chk("mismatch_cnt", 32'(mismatch_cnt_o), 32'(exp_mm));
    end
    repeat (2) @(negedge clk_i);
    chk("idle_busy", 32'(busy_o), 32'd0);
    chk("idle_awvalid", 32'(m_awvalid), 32'd0);
  endtask

  initial begin : stim
    int n;
    #1 rst_n = 0;
    #2;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_mm", 32'(mismatch_cnt_o), 32'd0);
    chk("rst_valids", {29'd0, m_awvalid, m_wvalid, m_arvalid}, 32'd0);
    chk("rst_readies", {30'd0, m_bready, m_rready}, 32'd0);
    repeat (3) @(negedge clk_i);
    rst_n = 1;

    run_seq(32'h100, 4'd0, 32'hA5A5_0000, 0, 2'b00, 16'h0, 16, 0);
    chk("t1_beat0", obs_w[0], 32'hA5A5_0000);
    chk("t1_err", 32'(err_o), 32'd0);

    run_seq(32'h200, 4'd15, 32'hFFFF_FFFE, 0, 2'b00, 16'h0, 16, 0);
    chk("t2_beat0", obs_w[0], 32'hFFFF_FFFE);
    chk("t2_beat1", obs_w[1], 32'hFFFF_FFFF);
    chk("t2_beat2", obs_w[2], 32'h0000_0000);
    chk("t2_beat15", obs_w[15], 32'h0000_000D);

    run_seq(32'h300, 4'd3, 32'h1234_5678, 5, 2'b00, 16'h0, 16, 1);

    run_seq(32'h400, 4'd7, 32'h1111_0000, 0, 2'b00, 16'h0088, 16, 0);
    chk("t4_mm_literal", 32'(mismatch_cnt_o), 32'd2);
    chk("t4_err_literal", 32'(err_o), 32'd1);

    run_seq(32'h500, 4'd1, 32'h0000_0005, 0, 2'b10, 16'h0, 16, 0);
    chk("t5_slverr", 32'(err_o), 32'd1);

    run_seq(32'h600, 4'd3, 32'h0000_0077, 0, 2'b00, 16'h0, 2, 0);
    chk("t6_early_rlast", 32'(err_o), 32'd1);

    cfg_stall = 0; cfg_bresp = 2'b00; cfg_mask = '0; cfg_early = 16;
    start_seq(32'h800, 4'd7, 32'h9000_0000);
    n = 0;
    while (!(m_wvalid && m_wdata == 32'h9000_0004) && n < 200) begin @(negedge clk_i); n++; end
    chk("reached_w_beat4", 32'(m_wvalid && m_wdata == 32'h9000_0004), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("midrst_valids", {29'd0, m_awvalid, m_wvalid, m_arvalid}, 32'd0);
    chk("midrst_readies", {30'd0, m_bready, m_rready}, 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    repeat (2) @(negedge clk_i);
    #3 rst_n = 1;

    run_seq(32'h700, 4'd5, 32'hCAFE_0000, 0, 2'b00, 16'h0, 16, 0);
    chk("t8_clean_err", 32'(err_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
